// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: consumer-side and memory-side handshake bundle for mem_arbiter.
interface mem_arbiter_if #(
    parameter int NUM_CONSUMERS = 4,
    parameter int ADDR_BITS = 8,
    parameter int DATA_BITS = 8
);
    logic [NUM_CONSUMERS-1:0] consumer_read_valid;
    logic [ADDR_BITS*NUM_CONSUMERS-1:0] consumer_read_address_flat;
    logic [NUM_CONSUMERS-1:0] consumer_read_ready;
    logic [DATA_BITS*NUM_CONSUMERS-1:0] consumer_read_data_flat;
    logic [NUM_CONSUMERS-1:0] consumer_write_valid;
    logic [ADDR_BITS*NUM_CONSUMERS-1:0] consumer_write_address_flat;
    logic [DATA_BITS*NUM_CONSUMERS-1:0] consumer_write_data_flat;
    logic [NUM_CONSUMERS-1:0] consumer_write_ready;
    logic mem_read_valid;
    logic [ADDR_BITS-1:0] mem_read_address;
    logic mem_read_ready;
    logic [DATA_BITS-1:0] mem_read_data;
    logic mem_write_valid;
    logic [ADDR_BITS-1:0] mem_write_address;
    logic [DATA_BITS-1:0] mem_write_data;
    logic mem_write_ready;
    logic timeout_err;

    modport master (
        input consumer_read_valid, consumer_read_address_flat, consumer_write_valid,
        input consumer_write_address_flat, consumer_write_data_flat,
        input mem_read_ready, mem_read_data, mem_write_ready,
        output consumer_read_ready, consumer_read_data_flat, consumer_write_ready,
        output mem_read_valid, mem_read_address, mem_write_valid, mem_write_address,
        output mem_write_data, timeout_err
    );

    modport slave (
        output consumer_read_valid, consumer_read_address_flat, consumer_write_valid,
        output consumer_write_address_flat, consumer_write_data_flat,
        output mem_read_ready, mem_read_data, mem_write_ready,
        input consumer_read_ready, consumer_read_data_flat, consumer_write_ready,
        input mem_read_valid, mem_read_address, mem_write_valid, mem_write_address,
        input mem_write_data, timeout_err
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin share of one memory channel, one transaction in flight.
// Define MEM_ARB_TIMEOUT_EN to bound memory wait states by TIMEOUT_CYCLES.
module mem_arbiter #(
    parameter int NUM_CONSUMERS = 4,
    parameter int ADDR_BITS = 8,
    parameter int DATA_BITS = 8,
    parameter int TIMEOUT_CYCLES = 255
) (
    input logic clk,
    input logic reset_n,
    mem_arbiter_if.master bus
);
    localparam int IW = NUM_CONSUMERS > 1 ? $clog2(NUM_CONSUMERS) : 1;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be within 1..255");
    end

    typedef enum logic [1:0] {IDLE, READ_WAIT, WRITE_WAIT, RELAY} state_t;

    state_t state;
    logic [IW-1:0] rr_ptr, grant, pick;
    logic found, timed_out;

    function automatic logic [IW-1:0] wrap(input int v);
        return IW'(v % NUM_CONSUMERS);
    endfunction

`ifdef MEM_ARB_TIMEOUT_EN
    logic [7:0] wait_cnt;
    assign timed_out = (state == READ_WAIT || state == WRITE_WAIT) && wait_cnt == 8'(TIMEOUT_CYCLES - 1);
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) wait_cnt <= '0;
        else wait_cnt <= (state == READ_WAIT || state == WRITE_WAIT) ? wait_cnt + 8'd1 : 8'd0;
`else
    assign timed_out = 1'b0;
`endif

    // Scan from the farthest offset down so the nearest requester after rr_ptr wins.
    always_comb begin
        pick = '0;
        found = 1'b0;
        for (int k = NUM_CONSUMERS - 1; k >= 0; k--) begin
            if (bus.consumer_read_valid[wrap(int'(rr_ptr) + k)] | bus.consumer_write_valid[wrap(int'(rr_ptr) + k)]) begin
                pick = wrap(int'(rr_ptr) + k);
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            rr_ptr <= '0;
            grant <= '0;
            bus.mem_read_valid <= 1'b0;
            bus.mem_read_address <= '0;
            bus.mem_write_valid <= 1'b0;
            bus.mem_write_address <= '0;
            bus.mem_write_data <= '0;
            bus.consumer_read_ready <= '0;
            bus.consumer_write_ready <= '0;
            bus.consumer_read_data_flat <= '0;
            bus.timeout_err <= 1'b0;
        end else begin
            case (state)
                IDLE: if (found) begin
                    grant <= pick;
                    if (bus.consumer_read_valid[pick]) begin
                        bus.mem_read_valid <= 1'b1;
                        bus.mem_read_address <= bus.consumer_read_address_flat[int'(pick)*ADDR_BITS +: ADDR_BITS];
                        state <= READ_WAIT;
                    end else begin
                        bus.mem_write_valid <= 1'b1;
                        bus.mem_write_address <= bus.consumer_write_address_flat[int'(pick)*ADDR_BITS +: ADDR_BITS];
                        bus.mem_write_data <= bus.consumer_write_data_flat[int'(pick)*DATA_BITS +: DATA_BITS];
                        state <= WRITE_WAIT;
                    end
                end
                READ_WAIT: if (bus.mem_read_ready || timed_out) begin
                    bus.mem_read_valid <= 1'b0;
                    bus.consumer_read_data_flat[int'(grant)*DATA_BITS +: DATA_BITS] <= bus.mem_read_ready ? bus.mem_read_data : '1;
                    bus.consumer_read_ready[grant] <= 1'b1;
                    bus.timeout_err <= bus.timeout_err | ~bus.mem_read_ready;
                    state <= RELAY;
                end
                WRITE_WAIT: if (bus.mem_write_ready || timed_out) begin
                    bus.mem_write_valid <= 1'b0;
                    bus.consumer_write_ready[grant] <= 1'b1;
                    bus.timeout_err <= bus.timeout_err | ~bus.mem_write_ready;
                    state <= RELAY;
                end
                RELAY: if (|bus.consumer_read_ready ? !bus.consumer_read_valid[grant] : !bus.consumer_write_valid[grant]) begin
                    bus.consumer_read_ready <= '0;
                    bus.consumer_write_ready <= '0;
                    rr_ptr <= wrap(int'(grant) + 1);
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
